// File: rtl/angle_search_pkg.sv
// Shared types and sizing helpers for the angle-search sequencer and its grid counter.
package angle_search_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SWEEP,
    WAIT_SORT,
    DONE
  } state_e;

  // Points per candidate: (2R+1) per axis, three axes.
  function automatic int grid_points(input int r);
    return (2 * r + 1) ** 3;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Candidate field offsets inside one {theta, phi, alpha} entry.
  function automatic int theta_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int phi_lsb(input int aw);
    return aw;
  endfunction

  function automatic int alpha_lsb(input int aw);
    return 0 * aw;
  endfunction

endpackage

// File: rtl/grid_offset_counter.sv
// Three nested -R..R axis counters (alpha innermost) with a linear point index.
// The k_*_o outputs give the offsets that take effect at the next clock edge.
module grid_offset_counter
  import angle_search_pkg::*;
#(
  parameter int R  = 2,
  parameter int KW = $clog2(R + 1) + 1,
  parameter int PW = width_of(grid_points(R))
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 adv_i,
  output logic signed [KW-1:0] k_theta_o,
  output logic signed [KW-1:0] k_phi_o,
  output logic signed [KW-1:0] k_alpha_o,
  output logic [PW-1:0]        idx_o,
  output logic                 wrap_o,
  output logic                 wrap_nxt_o
);

  localparam int                      P        = grid_points(R);
  localparam logic signed [KW-1:0]    KMIN     = KW'(-R);
  localparam logic signed [KW-1:0]    KMAX     = KW'(R);
  localparam logic [PW-1:0]           IDX_LAST = PW'(P - 1);

  logic signed [KW-1:0] kt_q, kt_d, kp_q, kp_d, ka_q, ka_d;
  logic [PW-1:0]        idx_q, idx_d;
  logic                 wrap_q, wrap_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    kt_d  = kt_q;
    kp_d  = kp_q;
    ka_d  = ka_q;
    idx_d = idx_q;
    if (clr_i) begin
      kt_d  = KMIN;
      kp_d  = KMIN;
      ka_d  = KMIN;
      idx_d = '0;
    end else if (adv_i) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (ka_q != KMAX) begin
        ka_d = ka_q + KW'(1);
      end else begin
        ka_d = KMIN;
        if (kp_q != KMAX) begin
          kp_d = kp_q + KW'(1);
        end else begin
          kp_d = KMIN;
          kt_d = (kt_q != KMAX) ? kt_q + KW'(1) : KMIN;
        end
      end
    end
    wrap_d = (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kt_q   <= '0;
      kp_q   <= '0;
      ka_q   <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      kt_q   <= kt_d;
      kp_q   <= kp_d;
      ka_q   <= ka_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  assign k_theta_o  = kt_d;
  assign k_phi_o    = kp_d;
  assign k_alpha_o  = ka_d;
  assign idx_o      = idx_q;
  assign wrap_o     = wrap_q;
  assign wrap_nxt_o = wrap_d;

endmodule

// File: rtl/angle_search_sequencer.sv
// Coarse-to-fine angle-search sequencer: sweeps a (2R+1)^3 grid around each candidate,
// halving the step each stage, with valid/ready output and a done pulse.
module angle_search_sequencer
  import angle_search_pkg::*;
#(
  parameter int N_CAND  = 10,
  parameter int AW      = 12,
  parameter int N_STAGE = 3,
  parameter int R       = 2,
  parameter int DELTA0  = 64,
  localparam int P      = grid_points(R),
  localparam int CW     = width_of(N_CAND),
  localparam int PW     = width_of(P),
  localparam int SW     = $clog2(N_STAGE) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sorted_rdy,
  input  logic [N_CAND*3*AW-1:0]   candidate_angle_buffer,
  input  logic                     angle_ready,
  output logic [AW-1:0]            theta,
  output logic [AW-1:0]            phi,
  output logic [AW-1:0]            alpha,
  output logic                     angle_valid,
  output logic [PW-1:0]            score_alpha_num,
  output logic [CW-1:0]            compare_num,
  output logic [SW-1:0]            stage,
  output logic                     stage_trigger,
  output logic                     if_last_angle,
  output logic                     if_final_angle,
  output logic                     busy,
  output logic                     done
);

  localparam int             KW         = $clog2(R + 1) + 1;
  localparam int             MW         = AW + $clog2(R) + 1;
  localparam int             BW         = N_CAND * 3 * AW;
  localparam int             TH_LSB     = theta_lsb(AW);
  localparam int             PH_LSB     = phi_lsb(AW);
  localparam int             AL_LSB     = alpha_lsb(AW);
  localparam logic [AW-1:0]  DELTA_INIT = AW'((DELTA0 > 0) ? DELTA0 : 1);
  localparam logic [CW-1:0]  LAST_CAND  = CW'(N_CAND - 1);
  localparam logic [SW-1:0]  LAST_STAGE = SW'(N_STAGE - 1);

  state_e               state_q, state_d;
  logic                 start_q, armed_q;
  logic [BW-1:0]        buf_q, buf_d;
  logic [AW-1:0]        delta_q, delta_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [CW-1:0]        cand_q, cand_d;
  logic [AW-1:0]        theta_q, theta_d, phi_q, phi_d, alpha_q, alpha_d;
  logic                 valid_q, valid_d, trig_q, trig_d, final_q, final_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 cnt_clr, cnt_adv, upd, hs, launch;
  logic [3*AW-1:0]      centre;
  logic signed [KW-1:0] kt_nxt, kp_nxt, ka_nxt;
  logic [PW-1:0]        idx;
  logic                 last, last_nxt;

  // Offset k*delta reduced modulo 2^AW; negative k wraps naturally.
  function automatic logic [AW-1:0] scaled(input logic signed [KW-1:0] k,
                                           input logic [AW-1:0] d);
    logic signed [MW-1:0] p;
    p = MW'(k) * signed'(MW'(d));
    return p[AW-1:0];
  endfunction

  grid_offset_counter #(
    .R (R),
    .KW(KW),
    .PW(PW)
  ) u_grid (
    .clk       (clk),
    .rst_n     (rst),
    .clr_i     (cnt_clr),
    .adv_i     (cnt_adv),
    .k_theta_o (kt_nxt),
    .k_phi_o   (kp_nxt),
    .k_alpha_o (ka_nxt),
    .idx_o     (idx),
    .wrap_o    (last),
    .wrap_nxt_o(last_nxt)
  );

  assign hs = valid_q & angle_ready;
  // A start held high across reset release must drop before it can launch again.
  assign launch = start & ~start_q & armed_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    delta_d = delta_q;
    stage_d = stage_q;
    cand_d  = cand_q;
    theta_d = theta_q;
    phi_d   = phi_q;
    alpha_d = alpha_q;
    valid_d = valid_q;
    final_d = final_q;
    busy_d  = busy_q;
    trig_d  = 1'b0;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_adv = 1'b0;
    upd     = 1'b0;
    centre  = '0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          buf_d   = candidate_angle_buffer;
          stage_d = '0;
          delta_d = DELTA_INIT;
          trig_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_clr = 1'b1;
        cand_d  = '0;
        valid_d = 1'b1;
        upd     = 1'b1;
        state_d = SWEEP;
      end
      SWEEP: begin
        if (hs) begin
          if (final_q) begin
            cnt_clr = 1'b1;
            cand_d  = '0;
            valid_d = 1'b0;
            final_d = 1'b0;
            if (stage_q == LAST_STAGE) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = WAIT_SORT;
            end
          end else begin
            cnt_adv = 1'b1;
            if (last) cand_d = cand_q + 1'b1;
            upd = 1'b1;
          end
        end
      end
      WAIT_SORT: begin
        if (sorted_rdy) begin
          buf_d   = candidate_angle_buffer;
          stage_d = stage_q + 1'b1;
          delta_d = (delta_q > AW'(1)) ? (delta_q >> 1) : AW'(1);
          trig_d  = 1'b1;
          state_d = LOAD;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (upd) begin
      centre  = buf_q[cand_d * (3 * AW) +: 3 * AW];
      theta_d = centre[TH_LSB +: AW] + scaled(kt_nxt, delta_q);
      phi_d   = centre[PH_LSB +: AW] + scaled(kp_nxt, delta_q);
      alpha_d = centre[AL_LSB +: AW] + scaled(ka_nxt, delta_q);
      final_d = last_nxt & (cand_d == LAST_CAND);
    end
  end

  // NOTE: the candidate buffer is a plain register bank, so it is reset with everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      buf_q   <= '0;
      delta_q <= '0;
      stage_q <= '0;
      cand_q  <= '0;
      theta_q <= '0;
      phi_q   <= '0;
      alpha_q <= '0;
      valid_q <= 1'b0;
      trig_q  <= 1'b0;
      final_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q <= state_d;
      start_q <= start;
      armed_q <= armed_q | ~start;
      buf_q   <= buf_d;
      delta_q <= delta_d;
      stage_q <= stage_d;
      cand_q  <= cand_d;
      theta_q <= theta_d;
      phi_q   <= phi_d;
      alpha_q <= alpha_d;
      valid_q <= valid_d;
      trig_q  <= trig_d;
      final_q <= final_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign theta           = theta_q;
  assign phi             = phi_q;
  assign alpha           = alpha_q;
  assign angle_valid     = valid_q;
  assign score_alpha_num = idx;
  assign compare_num     = cand_q;
  assign stage           = stage_q;
  assign stage_trigger   = trig_q;
  assign if_last_angle   = last;
  assign if_final_angle  = final_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_angle_search_sequencer.sv
// Scoreboard bench: expected triples are queued when a stage is launched and
// compared at every handshake; stalls, pulses, wrap and reset abort are checked too.
module tb_angle_search_sequencer;

  typedef struct packed {
    logic [11:0] th;
    logic [11:0] ph;
    logic [11:0] al;
    logic [4:0]  idx;
    logic        cmp;
    logic        last;
    logic        fin;
    logic [1:0]  stg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sorted_rdy = 1'b0;
  logic [71:0] cab = '0;
  logic        angle_ready = 1'b1;
  logic [11:0] theta, phi, alpha;
  logic        angle_valid;
  logic [4:0]  score_alpha_num;
  logic [0:0]  compare_num;
  logic [1:0]  stage;
  logic        stage_trigger, if_last_angle, if_final_angle, busy, done;

  angle_search_sequencer #(
    .N_CAND (2),
    .AW     (12),
    .N_STAGE(2),
    .R      (1),
    .DELTA0 (8)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .sorted_rdy            (sorted_rdy),
    .candidate_angle_buffer(cab),
    .angle_ready           (angle_ready),
    .theta                 (theta),
    .phi                   (phi),
    .alpha                 (alpha),
    .angle_valid           (angle_valid),
    .score_alpha_num       (score_alpha_num),
    .compare_num           (compare_num),
    .stage                 (stage),
    .stage_trigger         (stage_trigger),
    .if_last_angle         (if_last_angle),
    .if_final_angle        (if_final_angle),
    .busy                  (busy),
    .done                  (done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [35:0] hs_log[$];
  int          hs_cnt = 0, trig_cnt = 0, done_cnt = 0;
  logic        mon_en = 1'b0, bp = 1'b0;
  logic        stall_prev = 1'b0, trig_prev = 1'b0, done_prev = 1'b0;
  logic [49:0] prev_all = '0;
  logic [49:0] obs_all;
  logic [45:0] obs_pt;

  assign obs_all = {theta, phi, alpha, angle_valid, score_alpha_num, compare_num, stage,
                    stage_trigger, if_last_angle, if_final_angle, busy, done};
  assign obs_pt  = {theta, phi, alpha, score_alpha_num, compare_num, if_last_angle,
                    if_final_angle, stage};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [71:0] mk_buf(input int t0, p0, a0, t1, p1, a1);
    return {12'(t1), 12'(p1), 12'(a1), 12'(t0), 12'(p0), 12'(a0)};
  endfunction

  // Reference model: one stage of expected points, candidate-major, alpha innermost.
  task automatic push_stage(input logic [71:0] b, input int stg, input int d);
    logic [35:0] cv;
    exp_t        e;
    int          i;
    for (int c = 0; c < 2; c++) begin
      cv = b[36*c +: 36];
      for (int kt = -1; kt <= 1; kt++)
        for (int kp = -1; kp <= 1; kp++)
          for (int ka = -1; ka <= 1; ka++) begin
            i      = ((kt + 1) * 3 + (kp + 1)) * 3 + (ka + 1);
            e.th   = 12'((int'(cv[35:24]) + kt * d) & 4095);
            e.ph   = 12'((int'(cv[23:12]) + kp * d) & 4095);
            e.al   = 12'((int'(cv[11:0]) + ka * d) & 4095);
            e.idx  = 5'(i);
            e.cmp  = 1'(c);
            e.last = (i == 26);
            e.fin  = (i == 26) && (c == 1);
            e.stg  = 2'(stg);
            sb.push_back(e);
          end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) check("stall_hold", 64'(obs_all), 64'(prev_all));
      stall_prev = angle_valid && !angle_ready;
      prev_all   = obs_all;
      if (trig_prev) check("valid_after_load", 64'(angle_valid), 64'd1);
      trig_prev = stage_trigger;
      if (stage_trigger) trig_cnt++;
      if (done_prev) check("busy_after_done", 64'(busy), 64'd0);
      done_prev = done;
      if (done) begin
        done_cnt++;
        check("busy_during_done", 64'(busy), 64'd1);
      end
      if (angle_valid && angle_ready) begin
        hs_cnt++;
        hs_log.push_back({theta, phi, alpha});
        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) check("point", 64'(obs_pt), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp) angle_ready = ~angle_ready;
  endtask

  task automatic launch(input logic [71:0] b);
    start = 1'b0;
    tick();
    cab   = b;
    start = 1'b1;
    push_stage(b, 0, 8);
    tick();
  endtask

  task automatic wait_sweep_end();
    int n;
    n = 0;
    while (!(sb.size() == 0 && !angle_valid) && n < 2000) begin
      tick();
      n++;
    end
    check("sweep_drained", 64'(sb.size()), 64'd0);
    check("valid_low_after_stage", 64'(angle_valid), 64'd0);
  endtask

  task automatic pulse_sorted(input logic [71:0] b, input int stg, input int d);
    cab        = b;
    sorted_rdy = 1'b1;
    push_stage(b, stg, d);
    tick();
    sorted_rdy = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (!(done_cnt == target && !busy) && n < 2000) begin
      tick();
      n++;
    end
    check("done_pulses", 64'(done_cnt), 64'(target));
    check("busy_low_after_run", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [71:0] buf_a, buf_b, buf_c;
    int          base, hs0, tr0;
    buf_a = mk_buf(21, 42, 63, 84, 105, 126);
    buf_b = mk_buf(100, 200, 300, 400, 500, 600);
    buf_c = mk_buf(0, 4095, 2, 4000, 10, 4094);

    repeat (3) tick();
    check("reset_outputs", 64'(obs_all), 64'd0);
    rst = 1'b1;
    tick();
    mon_en = 1'b1;

    // Run A: nominal, early sorted_rdy ignored, WAIT_SORT stall, relatch.
    base = hs_log.size();
    hs0  = hs_cnt;
    launch(buf_a);
    repeat (10) tick();
    cab        = buf_b;
    sorted_rdy = 1'b1;
    tick();
    sorted_rdy = 1'b0;
    wait_sweep_end();
    check("stage0_handshakes", 64'(hs_cnt - hs0), 64'd54);
    check("stage0_triggers", 64'(trig_cnt), 64'd1);
    check("first_triple", 64'(hs_log[base]), 64'({12'd13, 12'd34, 12'd55}));
    check("second_triple", 64'(hs_log[base+1]), 64'({12'd13, 12'd34, 12'd63}));
    check("cand0_last_triple", 64'(hs_log[base+26]), 64'({12'd29, 12'd50, 12'd71}));
    repeat (5) tick();
    check("wait_sort_hold", 64'({angle_valid, busy, done, stage}), 64'({1'b0, 1'b1, 1'b0, 2'd0}));
    pulse_sorted(buf_b, 1, 4);
    wait_done(1);
    check("run_a_handshakes", 64'(hs_cnt - hs0), 64'd108);
    check("run_a_triggers", 64'(trig_cnt), 64'd2);

    // Run B: backpressure toggling every cycle.
    hs0 = hs_cnt;
    bp  = 1'b1;
    launch(buf_a);
    wait_sweep_end();
    check("bp_stage0_handshakes", 64'(hs_cnt - hs0), 64'd54);
    pulse_sorted(buf_a, 1, 4);
    wait_done(2);
    check("bp_handshakes", 64'(hs_cnt - hs0), 64'd108);
    bp          = 1'b0;
    angle_ready = 1'b1;

    // Run C: centres near zero and 4095 exercise modular wrap.
    base = hs_log.size();
    launch(buf_c);
    wait_sweep_end();
    check("wrap_first_triple", 64'(hs_log[base]), 64'({12'd4088, 12'd4087, 12'd4090}));
    check("wrap_theta8_row", 64'(hs_log[base+18]), 64'({12'd8, 12'd4087, 12'd4090}));
    pulse_sorted(buf_c, 1, 4);
    wait_done(3);

    // Run D: asynchronous abort mid-sweep, then start held high must not relaunch.
    launch(buf_a);
    repeat (20) tick();
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check("abort_outputs_cleared", 64'(obs_all), 64'd0);
    sb.delete();
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("start_held_ignored", 64'({busy, angle_valid, stage_trigger}), 64'd0);
    end
    stall_prev = 1'b0;
    trig_prev  = 1'b0;
    done_prev  = 1'b0;
    tr0        = trig_cnt;
    hs0        = hs_cnt;
    mon_en     = 1'b1;
    launch(buf_a);
    wait_sweep_end();
    pulse_sorted(buf_a, 1, 4);
    wait_done(4);
    check("after_abort_handshakes", 64'(hs_cnt - hs0), 64'd108);
    check("after_abort_triggers", 64'(trig_cnt - tr0), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/angle_search_sequencer.md
Name: angle_search_sequencer

Overview:
Parametrised coarse-to-fine angle-search sequencer for the match pipeline. For each of N_STAGE stages it sweeps a (2R+1)^3 grid of theta/phi/alpha triples around each of N_CAND candidate centres and streams the triples to the scoring datapath with valid/ready backpressure. Between stages it waits for the downstream sorter (sorted_rdy) to return a refreshed candidate buffer, and halves the grid step each stage. Compared with the previous fixed 10-candidate/12-bit machine, it is generalised in candidate count, angle width, stage count and grid radius, and it adds output backpressure and a done handshake.

Parameters:
N_CAND, 10, number of candidate centres per stage
AW, 12, angle width in bits; all angle arithmetic is modulo 2^AW
N_STAGE, 3, number of refinement stages
R, 2, grid half-width in steps per axis (points per axis = 2R+1)
DELTA0, 64, stage-0 step size; stage s uses max(DELTA0>>s, 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  level input; a rising edge sampled in IDLE launches a search
sorted_rdy  in  1  one-cycle pulse from the sorter: new candidate buffer is valid
candidate_angle_buffer  in  N_CAND*3*AW  candidate i = bits [3AW*(i+1)-1 -: 3AW] = {theta, phi, alpha}
angle_ready  in  1  downstream accepts the current triple
theta  out  AW  current theta
phi  out  AW  current phi
alpha  out  AW  current alpha
angle_valid  out  1  theta/phi/alpha are valid
score_alpha_num  out  clog2((2R+1)^3)  point index within the current candidate
compare_num  out  clog2(N_CAND)  current candidate index
stage  out  clog2(N_STAGE)+1  current stage number
stage_trigger  out  1  one-cycle pulse at the start of each stage
if_last_angle  out  1  current triple is the last point of this candidate
if_final_angle  out  1  current triple is the last point of the stage
busy  out  1  high from LOAD until the end of DONE
done  out  1  one-cycle pulse when all stages are complete

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output is 0; internal start_q=0.
- State IDLE: on a start rising edge (start & ~start_q), latch the buffer, set stage=0 and delta=DELTA0, and go to LOAD.
- State LOAD (1 cycle): stage_trigger=1; clear the candidate and point counters; go to SWEEP.
- The first angle_valid appears on the cycle after LOAD.
- State SWEEP: triple = centre + k*delta (mod 2^AW) per axis, with k in -R..R.
  - Order: alpha is innermost, then phi, then theta, then candidate.
  - Negative offsets wrap; e.g. 3 - 64 = 4035 when AW=12.
- Handshake: the counters advance only when angle_valid & angle_ready.
  - While angle_valid=1 and angle_ready=0, every output holds stable.
  - angle_valid stays continuously 1 throughout SWEEP.
  - The outputs are registered.
- if_last_angle = (score_alpha_num == P-1), where P=(2R+1)^3.
- if_final_angle = if_last_angle & (compare_num == N_CAND-1).
- Both flags are aligned with the triple they describe.
- On the handshake of the final angle of a stage:
  - If stage == N_STAGE-1, go to DONE.
  - Otherwise go to WAIT_SORT with angle_valid=0.
- State WAIT_SORT:
  - sorted_rdy=1 relatches candidate_angle_buffer, increments stage, sets delta = max(delta>>1, 1), and goes to LOAD.
  - sorted_rdy is ignored in every other state; a pulse arriving early is lost.
- State DONE (1 cycle): done=1, busy=1; then go to IDLE. Another search needs a new start rising edge.
- start is ignored outside IDLE.
- An asynchronous reset in any state aborts immediately; the next search needs a new start edge after reset release.
- Width rules:
  - Offset multiply k*delta is computed at AW+clog2(R)+1 bits, then truncated to AW.
  - Counters are sized exactly; no overflow beyond P-1 or N_CAND-1.

Decomposition:
- Shared package angle_search_pkg holds:
  - state enum (IDLE, LOAD, SWEEP, WAIT_SORT, DONE)
  - localparams P, CW=clog2(N_CAND), PW=clog2(P)
  - candidate field offsets (THETA_LSB=2AW, PHI_LSB=AW, ALPHA_LSB=0)
- Sub-module grid_offset_counter (one instance):
  - three nested −R..R axis counters with an advance enable
  - outputs the signed offsets, the linear point index and a wrap flag
  - the top level owns the FSM, the candidate latch and the modular adds

Test Plan:
Test parameters unless noted: N_CAND=2, AW=12, N_STAGE=2, R=1, DELTA0=8, candidates {21,42,63} and {84,105,126}.
1. Reset, then a start edge with angle_ready=1 → stage_trigger pulses once; the first triple is (13,34,55); the second is (13,34,63); the 27th has if_last_angle=1, (29,50,71) and score_alpha_num=26.
2. Same run → the 54th handshake shows if_final_angle=1 and compare_num=1; the FSM enters WAIT_SORT with angle_valid=0; a sorted_rdy pulse there gives stage=1 and a first triple with delta=4; after 54 more handshakes done pulses once and busy falls.
3. Backpressure: toggle angle_ready 1/0 each cycle → outputs are constant on every stall cycle; exactly 54 distinct triples per stage; none are dropped or duplicated.
4. Wrap: candidate {0,4095,2}, DELTA0=8 → the first triple is (4088,4087,4090) and the theta=8 row is reached without error.
5. A sorted_rdy pulse during SWEEP is ignored, and the FSM still stalls in WAIT_SORT; rst pulled low mid-SWEEP clears all outputs immediately; start held high after reset release does nothing until a fresh rising edge.
